bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 42 ++++
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Signal bundle between two memory masters, the arbiter and the shared downstream bus.
// The "master" modport is the surrounding system's view; "slave" is the arbiter's view.
interface bus_arbiter_if;
  logic        m0_mem_valid;
  logic [31:0] m0_mem_addr;
  logic [31:0] m0_mem_wdata;
  logic [3:0]  m0_mem_wstrb;
  logic        m0_mem_ready;
  logic [31:0] m0_mem_rdata;

  logic        m1_mem_valid;
  logic [31:0] m1_mem_addr;
  logic [31:0] m1_mem_wdata;
  logic [3:0]  m1_mem_wstrb;
  logic        m1_mem_ready;
  logic [31:0] m1_mem_rdata;

  logic        s_mem_valid;
  logic [31:0] s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [3:0]  s_mem_wstrb;
  logic        s_mem_ready;
  logic [31:0] s_mem_rdata;

  modport master (
    output m0_mem_valid, m0_mem_addr, m0_mem_wdata, m0_mem_wstrb,
    input  m0_mem_ready, m0_mem_rdata,
    output m1_mem_valid, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb,
    input  m1_mem_ready, m1_mem_rdata,
    input  s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb,
    output s_mem_ready, s_mem_rdata
  );

  modport slave (
    input  m0_mem_valid, m0_mem_addr, m0_mem_wdata, m0_mem_wstrb,
    output m0_mem_ready, m0_mem_rdata,
    input  m1_mem_valid, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb,
    output m1_mem_ready, m1_mem_rdata,
    output s_mem_valid, s_mem_addr, s_mem_wdata, s_mem_wstrb,
    input  s_mem_ready, s_mem_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a shared memory bus with a per-transfer
// wait-cycle timeout that completes a stuck transfer with all-ones read data.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_if.slave      bus,
  input  logic              timeout_clr,
  output logic              timeout_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_grant;
  logic        w_last_grant_next;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_next;
  logic        r_timeout_flag;
  logic        w_timeout_flag_next;
  logic        w_timeout_hit;

  logic [1:0]  w_m_valid;
  logic [31:0] w_m_addr  [2];
  logic [31:0] w_m_wdata [2];
  logic [3:0]  w_m_wstrb [2];
  logic [1:0]  w_m_ready;
  logic [31:0] w_m_rdata [2];
  logic [1:0]  w_granted;

  logic        w_busy;
  logic        w_sel;
  logic        w_s_valid;
  logic [31:0] w_s_addr;
  logic [31:0] w_s_wdata;
  logic [3:0]  w_s_wstrb;
  logic        w_ready_pulse;
  logic [31:0] w_rdata_sel;

  assign w_m_valid    = {bus.m1_mem_valid, bus.m0_mem_valid};
  assign w_m_addr[0]  = bus.m0_mem_addr;
  assign w_m_addr[1]  = bus.m1_mem_addr;
  assign w_m_wdata[0] = bus.m0_mem_wdata;
  assign w_m_wdata[1] = bus.m1_mem_wdata;
  assign w_m_wstrb[0] = bus.m0_mem_wstrb;
  assign w_m_wstrb[1] = bus.m1_mem_wstrb;

  // Reset gates every output so nothing leaks out while the state register is being cleared.
  assign w_busy = !reset && ((r_state == BUSY0) || (r_state == BUSY1));
  assign w_sel  = (r_state == BUSY1);

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_wait_cnt_next   = r_wait_cnt;
    w_timeout_hit     = 1'b0;
    w_s_valid         = 1'b0;
    w_s_addr          = '0;
    w_s_wdata         = '0;
    w_s_wstrb         = '0;
    w_ready_pulse     = 1'b0;
    w_rdata_sel       = bus.s_mem_rdata;

    if (w_busy) begin
      w_s_valid = w_m_valid[w_sel];
      w_s_addr  = w_m_addr[w_sel];
      w_s_wdata = w_m_wdata[w_sel];
      w_s_wstrb = w_m_wstrb[w_sel];
      if (!w_m_valid[w_sel]) begin
        // Master withdrew its request: abandon quietly, fairness history untouched.
        w_state_next    = IDLE;
        w_wait_cnt_next = '0;
      end else if (bus.s_mem_ready) begin
        w_ready_pulse     = 1'b1;
        w_state_next      = IDLE;
        w_last_grant_next = w_sel;
        w_wait_cnt_next   = '0;
      end else if (r_wait_cnt == TIMEOUT_CNT) begin
        w_ready_pulse     = 1'b1;
        w_rdata_sel       = 32'hFFFF_FFFF;
        w_s_valid         = 1'b0;
        w_timeout_hit     = 1'b1;
        w_state_next      = IDLE;
        w_last_grant_next = w_sel;
        w_wait_cnt_next   = '0;
      end else if (r_wait_cnt != CNT_MAX) begin
        w_wait_cnt_next = r_wait_cnt + 16'd1;
      end
    end else if (r_state == IDLE) begin
      w_wait_cnt_next = '0;
      unique case (w_m_valid)
        2'b01:   w_state_next = BUSY0;
        2'b10:   w_state_next = BUSY1;
        2'b11:   w_state_next = r_last_grant ? BUSY0 : BUSY1;
        default: w_state_next = IDLE;
      endcase
    end else begin
      w_state_next    = IDLE;
      w_wait_cnt_next = '0;
    end

    // A timeout in the same cycle as a clear request leaves the flag set.
    if (w_timeout_hit) begin
      w_timeout_flag_next = 1'b1;
    end else if (timeout_clr) begin
      w_timeout_flag_next = 1'b0;
    end else begin
      w_timeout_flag_next = r_timeout_flag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_wait_cnt     <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_last_grant   <= w_last_grant_next;
      r_wait_cnt     <= w_wait_cnt_next;
      r_timeout_flag <= w_timeout_flag_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign w_granted[gi] = w_busy && (w_sel == 1'(gi));
      assign w_m_ready[gi] = w_granted[gi] && w_ready_pulse;
      assign w_m_rdata[gi] = w_granted[gi] ? w_rdata_sel : 32'h0;
    end
  endgenerate

  assign bus.m0_mem_ready = w_m_ready[0];
  assign bus.m1_mem_ready = w_m_ready[1];
  assign bus.m0_mem_rdata = w_m_rdata[0];
  assign bus.m1_mem_rdata = w_m_rdata[1];
  assign bus.s_mem_valid  = w_s_valid;
  assign bus.s_mem_addr   = w_s_addr;
  assign bus.s_mem_wdata  = w_s_wdata;
  assign bus.s_mem_wstrb  = w_s_wstrb;
  assign timeout_flag     = r_timeout_flag;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios followed by randomized master/slave traffic,
// every cycle compared against a transfer-level reference model.
module tb_bus_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  logic timeout_clr;
  logic timeout_flag;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .timeout_clr  (timeout_clr),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the bus (-1 = nobody), how long it has waited,
  // who won the previous completed transfer, and the sticky timeout indication.
  int   owner  = -1;
  int   waited = 0;
  int   prev   = 1;
  bit   flag_m = 1'b0;

  logic [1:0]  e_rdy;
  logic        obs_sv;
  logic [31:0] obs_sa;
  logic [1:0]  obs_rdy;
  logic [31:0] obs_rd [2];
  logic        obs_flag;

  task automatic set_m(input int i, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (i == 0) begin
      bus.m0_mem_valid = v; bus.m0_mem_addr = a; bus.m0_mem_wdata = d; bus.m0_mem_wstrb = s;
    end else begin
      bus.m1_mem_valid = v; bus.m1_mem_addr = a; bus.m1_mem_wdata = d; bus.m1_mem_wstrb = s;
    end
  endtask

  task automatic step();
    logic        mv [2];
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic        e_sv;
    logic [31:0] e_sa, e_sw;
    logic [3:0]  e_ss;
    logic [31:0] e_rd [2];
    bit          tmo;
    @(negedge clk);
    mv[0] = bus.m0_mem_valid; ma[0] = bus.m0_mem_addr; mw[0] = bus.m0_mem_wdata; ms[0] = bus.m0_mem_wstrb;
    mv[1] = bus.m1_mem_valid; ma[1] = bus.m1_mem_addr; mw[1] = bus.m1_mem_wdata; ms[1] = bus.m1_mem_wstrb;
    e_sv = 1'b0; e_sa = '0; e_sw = '0; e_ss = '0;
    e_rdy = 2'b00; e_rd[0] = '0; e_rd[1] = '0; tmo = 1'b0;
    if (!reset && owner >= 0) begin
      e_sv = mv[owner]; e_sa = ma[owner]; e_sw = mw[owner]; e_ss = ms[owner];
      e_rd[owner] = bus.s_mem_rdata;
      if (mv[owner]) begin
        if (bus.s_mem_ready) begin
          e_rdy[owner] = 1'b1;
        end else if (waited == TO) begin
          e_rdy[owner] = 1'b1; e_rd[owner] = 32'hFFFF_FFFF; e_sv = 1'b0; tmo = 1'b1;
        end
      end
    end
    obs_sv = bus.s_mem_valid; obs_sa = bus.s_mem_addr;
    obs_rdy = {bus.m1_mem_ready, bus.m0_mem_ready};
    obs_rd[0] = bus.m0_mem_rdata; obs_rd[1] = bus.m1_mem_rdata;
    obs_flag = timeout_flag;
    check_eq("s_valid", obs_sv, e_sv);
    check_eq("s_addr", obs_sa, e_sa);
    check_eq("s_wdata", bus.s_mem_wdata, e_sw);
    check_eq("s_wstrb", bus.s_mem_wstrb, e_ss);
    check_eq("m0_ready", obs_rdy[0], e_rdy[0]);
    check_eq("m1_ready", obs_rdy[1], e_rdy[1]);
    check_eq("m0_rdata", obs_rd[0], e_rd[0]);
    check_eq("m1_rdata", obs_rd[1], e_rd[1]);
    check_eq("timeout_flag", obs_flag, flag_m);
    if (e_rdy != 2'b00)
      $display("xfer m%0d addr=%h wstrb=%h rdata=%h%s", owner, ma[owner], ms[owner],
               e_rd[owner], tmo ? " (timeout)" : "");
    if (reset) begin
      owner = -1; waited = 0; prev = 1; flag_m = 1'b0;
    end else begin
      if (tmo) flag_m = 1'b1;
      else if (timeout_clr) flag_m = 1'b0;
      if (owner < 0) begin
        if (mv[0] && mv[1]) owner = 1 - prev;
        else if (mv[0]) owner = 0;
        else if (mv[1]) owner = 1;
        waited = 0;
      end else if (!mv[owner]) begin
        owner = -1;
      end else if (e_rdy[owner]) begin
        prev = owner; owner = -1;
      end else begin
        waited++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic new_req(input int i);
    set_m(i, 1'b1, $urandom, $urandom, ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'h0);
  endtask

  task automatic agents(input int stall_p);
    logic v;
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? bus.m0_mem_valid : bus.m1_mem_valid;
      if (e_rdy[i]) begin
        if ($urandom_range(0, 1) != 0) new_req(i);
        else set_m(i, 1'b0, '0, '0, '0);
      end else if (!v) begin
        if ($urandom_range(0, 3) == 0) new_req(i);
      end else if ($urandom_range(0, 199) == 0) begin
        set_m(i, 1'b0, '0, '0, '0);
      end
    end
    bus.s_mem_ready = ($urandom_range(0, 99) < stall_p);
    bus.s_mem_rdata = $urandom;
    timeout_clr     = ($urandom_range(0, 19) == 0);
    reset           = ($urandom_range(0, 299) == 0);
  endtask

  int grants [$];
  int cyc;
  bit seen;

  initial begin
    reset = 1'b1; timeout_clr = 1'b0;
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    bus.s_mem_ready = 1'b0; bus.s_mem_rdata = '0;
    do_reset();
    step();

    // Single m0 read, slave answers two cycles after the request appears downstream.
    set_m(0, 1'b1, 32'h0000_1000, '0, 4'h0);
    step();
    step();
    check_eq("r031_sv_t1", obs_sv, 1);
    check_eq("r031_addr_t1", obs_sa, 32'h0000_1000);
    step();
    bus.s_mem_ready = 1'b1; bus.s_mem_rdata = 32'hDEAD_BEEF;
    step();
    check_eq("r031_ready", obs_rdy[0], 1);
    check_eq("r031_rdata", obs_rd[0], 32'hDEAD_BEEF);
    check_eq("r031_m1_ready", obs_rdy[1], 0);
    set_m(0, 1'b0, '0, '0, '0);
    bus.s_mem_ready = 1'b0;
    step();

    // Both masters hammering from reset release: strict alternation starting with m0.
    set_m(0, 1'b1, 32'h0000_0100, 32'h1, 4'h0);
    set_m(1, 1'b1, 32'h0000_0200, 32'h2, 4'h0);
    do_reset();
    bus.s_mem_ready = 1'b1; bus.s_mem_rdata = 32'h5555_0000;
    for (int k = 0; k < 12; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (obs_rdy[i]) begin
          grants.push_back(i);
          check_eq("r032_addr_owner", {30'd0, obs_sa[9:8]}, 32'(i + 1));
          set_m(i, 1'b1, obs_sa + 32'd1, 32'(k), 4'h0);
        end
      end
    end
    check_eq("r032_count", grants.size(), 6);
    foreach (grants[j]) check_eq("r032_order", grants[j], j % 2);
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    bus.s_mem_ready = 1'b0;
    step();

    // m1 write against a dead slave: forced completion, sticky flag, then clear.
    set_m(1, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'hF);
    cyc = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      cyc++;
      if (obs_rdy[1]) seen = 1'b1;
    end
    check_eq("r033_seen", seen, 1);
    check_eq("r033_cycles", cyc, 6);
    check_eq("r033_rdata", obs_rd[1], 32'hFFFF_FFFF);
    set_m(1, 1'b0, '0, '0, '0);
    step();
    check_eq("r033_flag_set", obs_flag, 1);
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    step();
    check_eq("r033_flag_clr", obs_flag, 0);

    // Slave answers exactly on the timeout cycle: real data wins.
    set_m(0, 1'b1, 32'h0000_4000, '0, 4'h0);
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin
        bus.s_mem_ready = 1'b1; bus.s_mem_rdata = 32'h1234_5678;
      end
      step();
    end
    check_eq("r034_ready", obs_rdy[0], 1);
    check_eq("r034_rdata", obs_rd[0], 32'h1234_5678);
    set_m(0, 1'b0, '0, '0, '0);
    bus.s_mem_ready = 1'b0;
    step();
    check_eq("r034_flag", obs_flag, 0);

    // Reset in the middle of a stalled m0 transfer.
    set_m(0, 1'b1, 32'h0000_6000, '0, 4'h0);
    step(); step(); step();
    reset = 1'b1;
    step();
    check_eq("r035_rst_sv", obs_sv, 0);
    check_eq("r035_rst_rdy", obs_rdy, 0);
    reset = 1'b0;
    set_m(1, 1'b1, 32'h0000_5000, '0, 4'h0);
    step();
    check_eq("r035_idle_sv", obs_sv, 0);
    step();
    check_eq("r035_grant_sv", obs_sv, 1);
    check_eq("r035_grant_m0", obs_sa, 32'h0000_6000);
    bus.s_mem_ready = 1'b1;
    step();
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    bus.s_mem_ready = 1'b0;
    step();

    // Randomized traffic; slave alternates between responsive and sluggish phases.
    for (int n = 0; n < 3000; n++) begin
      agents(((n / 200) % 2 == 0) ? 40 : 8);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
